// File: rtl/trireg_pkg.sv
// Shared types and the per-bit resolution function for the trireg net model.
package trireg_pkg;

   typedef enum logic [1:0] {
      MODE_WIRE = 2'd0,
      MODE_WAND = 2'd1,
      MODE_WOR  = 2'd2
   } res_mode_e;

   // Upper bound on drivers handled by resolve_bit; narrower driver sets are zero-padded.
   localparam int MAX_DRV = 32;

   typedef struct packed {
      logic val;
      logic x;
      logic floating;
   } bit_state_t;

   typedef struct packed {
      logic val;
      logic conflict;
      logic driven;
   } res_bit_t;

   function automatic res_bit_t resolve_bit(input res_mode_e mode,
                                            input logic [MAX_DRV-1:0] val,
                                            input logic [MAX_DRV-1:0] en);
      res_bit_t r;
      logic     any_one;
      logic     any_zero;
      any_one    = |(val & en);
      any_zero   = |(~val & en);
      r.driven   = |en;
      r.val      = 1'b0;
      r.conflict = 1'b0;
      case (mode)
         MODE_WIRE: begin
            r.val      = any_one & ~any_zero;
            r.conflict = any_one & any_zero;
         end
         MODE_WAND: r.val = r.driven & ~any_zero;
         MODE_WOR:  r.val = any_one;
         default: begin
            r.val      = 1'b0;
            r.conflict = 1'b0;
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/trireg_resolver_bit_cell.sv
// One resolved net bit with charge-hold register; decay counter present only when
// TRIREG_DECAY_EN is defined.
module trireg_bit_cell
   import trireg_pkg::*;
#(
   parameter int        N_DRV        = 3,
   parameter res_mode_e MODE         = MODE_WIRE,
   parameter int        DECAY_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sample_i,
   input  logic [N_DRV-1:0] val_i,
   input  logic [N_DRV-1:0] en_i,
   output bit_state_t       state_o,
   output logic             conflict_o
);

   logic [MAX_DRV-1:0] val_pad_s;
   logic [MAX_DRV-1:0] en_pad_s;
   res_bit_t           res_s;
   bit_state_t         state_q;
   bit_state_t         state_d;

`ifdef TRIREG_DECAY_EN
   localparam int                DCNT_W    = $clog2(DECAY_CYCLES + 1);
   localparam logic [DCNT_W-1:0] DECAY_MAX = DCNT_W'(DECAY_CYCLES);
   logic [DCNT_W-1:0] dcnt_q;
   logic [DCNT_W-1:0] dcnt_d;
`endif

   // Pad driver vectors to the fixed width the resolution function expects.
   always_comb begin
      val_pad_s              = '0;
      en_pad_s               = '0;
      val_pad_s[N_DRV-1:0]   = val_i;
      en_pad_s[N_DRV-1:0]    = en_i;
      res_s                  = resolve_bit(MODE, val_pad_s, en_pad_s);
      conflict_o             = sample_i & res_s.conflict;
   end

   // Next-state: drive, hold (floating), or decay the held charge to unknown.
   always_comb begin
      state_d = state_q;
`ifdef TRIREG_DECAY_EN
      dcnt_d  = dcnt_q;
`endif
      if (sample_i) begin
         if (res_s.driven) begin
            state_d.val      = res_s.val & ~res_s.conflict;
            state_d.x        = res_s.conflict;
            state_d.floating = 1'b0;
`ifdef TRIREG_DECAY_EN
            dcnt_d           = '0;
`endif
         end else begin
            state_d.floating = 1'b1;
`ifdef TRIREG_DECAY_EN
            if (dcnt_q != DECAY_MAX) begin
               dcnt_d = dcnt_q + DCNT_W'(1);
               if (dcnt_d == DECAY_MAX) begin
                  state_d.x   = 1'b1;
                  state_d.val = 1'b0;
               end else begin
                  state_d.x   = state_q.x;
                  state_d.val = state_q.val;
               end
            end else begin
               dcnt_d = dcnt_q;
            end
`endif
         end
      end else begin
         state_d = state_q;
      end
   end

   // Hold register; an uncharged trireg reads as unknown and floating.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= '{val: 1'b0, x: 1'b1, floating: 1'b1};
`ifdef TRIREG_DECAY_EN
         dcnt_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
`ifdef TRIREG_DECAY_EN
         dcnt_q  <= dcnt_d;
`endif
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/trireg_resolver.sv
// Multi-driver trireg net model: per-bit resolution cells, conflict counter, valid.
// Optional held-charge decay is enabled with TRIREG_DECAY_EN.
module trireg_resolver
   import trireg_pkg::*;
#(
   parameter int        N_DRV        = 3,
   parameter int        WIDTH        = 4,
   parameter res_mode_e MODE         = MODE_WIRE,
   parameter int        DECAY_CYCLES = 3,
   parameter int        CNT_W        = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [N_DRV*WIDTH-1:0] drv_val,
   input  logic [N_DRV*WIDTH-1:0] drv_en,
   output logic                   out_valid,
   output logic [WIDTH-1:0]       res_val,
   output logic [WIDTH-1:0]       res_x,
   output logic [WIDTH-1:0]       res_float,
   output logic [CNT_W-1:0]       conflict_cnt
);

   logic [WIDTH-1:0] conflict_s;
   logic             conflict_any_s;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             valid_q;

   for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      logic [N_DRV-1:0] v_s;
      logic [N_DRV-1:0] e_s;
      bit_state_t       st_s;

      // Gather bit b of every driver into one vector.
      always_comb begin
         v_s = '0;
         e_s = '0;
         for (int i = 0; i < N_DRV; i++) begin
            v_s[i] = drv_val[i*WIDTH+b];
            e_s[i] = drv_en[i*WIDTH+b];
         end
      end

      trireg_bit_cell #(
         .N_DRV        (N_DRV),
         .MODE         (MODE),
         .DECAY_CYCLES (DECAY_CYCLES)
      ) u_cell (
         .clk        (clk),
         .rst        (rst),
         .sample_i   (in_valid),
         .val_i      (v_s),
         .en_i       (e_s),
         .state_o    (st_s),
         .conflict_o (conflict_s[b])
      );

      assign res_val[b]   = st_s.val;
      assign res_x[b]     = st_s.x;
      assign res_float[b] = st_s.floating;
   end

   // Saturating count of samples carrying at least one conflicting bit.
   always_comb begin
      conflict_any_s = |conflict_s;
      if (conflict_any_s && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter and valid registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         valid_q <= in_valid;
      end
   end

   assign conflict_cnt = cnt_q;
   assign out_valid    = valid_q;

endmodule

// File: tb/tb_trireg_resolver.sv
// Scoreboard bench for trireg_resolver: WIRE, WOR and WAND instances on shared drivers.
module tb_trireg_resolver;
   import trireg_pkg::*;

   typedef struct {
      logic [3:0]  v;
      logic [3:0]  x;
      logic [3:0]  f;
      logic [15:0] c;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        iv_w, iv_o, iv_a;
   logic [11:0] drv_val, drv_en;

   logic        w_ov, o_ov, a_ov;
   logic [3:0]  w_v, w_x, w_f, o_v, o_x, o_f, a_v, a_x, a_f;
   logic [15:0] w_c, o_c, a_c;

   exp_t q_w[$];
   exp_t q_o[$];
   exp_t q_a[$];

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [15:0] exp_cnt = 16'd0;
   logic        decay_on;

   always #5 clk = ~clk;

   trireg_resolver #(.N_DRV(3), .WIDTH(4), .MODE(MODE_WIRE), .DECAY_CYCLES(3), .CNT_W(16)) u_wire (
      .clk(clk), .rst(rst), .in_valid(iv_w), .drv_val(drv_val), .drv_en(drv_en),
      .out_valid(w_ov), .res_val(w_v), .res_x(w_x), .res_float(w_f), .conflict_cnt(w_c));

   trireg_resolver #(.N_DRV(3), .WIDTH(4), .MODE(MODE_WOR), .DECAY_CYCLES(3), .CNT_W(16)) u_wor (
      .clk(clk), .rst(rst), .in_valid(iv_o), .drv_val(drv_val), .drv_en(drv_en),
      .out_valid(o_ov), .res_val(o_v), .res_x(o_x), .res_float(o_f), .conflict_cnt(o_c));

   trireg_resolver #(.N_DRV(3), .WIDTH(4), .MODE(MODE_WAND), .DECAY_CYCLES(3), .CNT_W(16)) u_wand (
      .clk(clk), .rst(rst), .in_valid(iv_a), .drv_val(drv_val), .drv_en(drv_en),
      .out_valid(a_ov), .res_val(a_v), .res_x(a_x), .res_float(a_f), .conflict_cnt(a_c));

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic chk_out(input string nm, input logic [3:0] v, x, f, input logic [15:0] c,
                          input exp_t e);
      chk({nm, "_val"},   {28'd0, v}, {28'd0, e.v});
      chk({nm, "_x"},     {28'd0, x}, {28'd0, e.x});
      chk({nm, "_float"}, {28'd0, f}, {28'd0, e.f});
      chk({nm, "_cnt"},   {16'd0, c}, {16'd0, e.c});
   endtask

   task automatic spurious(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s_spurious_valid: got out_valid=1 expected no pending sample", nm);
   endtask

   // Monitors: pop and compare whenever an instance presents a result.
   always @(negedge clk) begin
      exp_t e;
      if (w_ov === 1'b1) begin
         if (q_w.size() == 0) spurious("wire");
         else begin e = q_w.pop_front(); chk_out("wire", w_v, w_x, w_f, w_c, e); end
      end
      if (o_ov === 1'b1) begin
         if (q_o.size() == 0) spurious("wor");
         else begin e = q_o.pop_front(); chk_out("wor", o_v, o_x, o_f, o_c, e); end
      end
      if (a_ov === 1'b1) begin
         if (q_a.size() == 0) spurious("wand");
         else begin e = q_a.pop_front(); chk_out("wand", a_v, a_x, a_f, a_c, e); end
      end
   end

   task automatic wsamp(input logic [11:0] val, input logic [11:0] en,
                        input logic [3:0] ev, ex, ef, input logic conf);
      @(negedge clk);
      if (conf && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      q_w.push_back('{ev, ex, ef, exp_cnt});
      drv_val = val;
      drv_en  = en;
      iv_w    = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         iv_w = 1'b0; iv_o = 1'b0; iv_a = 1'b0;
      end
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, "_valid"}, {31'd0, w_ov}, 32'd0);
      chk({nm, "_val"},   {28'd0, w_v},  32'h0);
      chk({nm, "_x"},     {28'd0, w_x},  32'hF);
      chk({nm, "_float"}, {28'd0, w_f},  32'hF);
      chk({nm, "_cnt"},   {16'd0, w_c},  32'h0);
   endtask

   task automatic orand(input logic [11:0] val, input logic [11:0] en,
                        input logic [3:0] ev_or, input logic [3:0] ev_and);
      @(negedge clk);
      q_o.push_back('{ev_or, 4'h0, 4'h0, 16'h0});
      q_a.push_back('{ev_and, 4'h0, 4'h0, 16'h0});
      drv_val = val;
      drv_en  = en;
      iv_o    = 1'b1;
      iv_a    = 1'b1;
   endtask

   initial begin
`ifdef TRIREG_DECAY_EN
      decay_on = 1'b1;
`else
      decay_on = 1'b0;
`endif
      rst = 1'b1; iv_w = 1'b0; iv_o = 1'b0; iv_a = 1'b0;
      drv_val = 12'h000; drv_en = 12'h000;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      rst = 1'b0;

      // Single driver, then WIRE conflict on bit 0, then clean drive again.
      wsamp(12'h00A, 12'h00F, 4'hA, 4'h0, 4'h0, 1'b0);
      wsamp(12'h01A, 12'h01F, 4'hA, 4'h1, 4'h0, 1'b1);
      wsamp(12'h00A, 12'h00F, 4'hA, 4'h0, 4'h0, 1'b0);

      // Floating samples separated by idle cycles; the third one decays if enabled.
      wsamp(12'h000, 12'h000, 4'hA, 4'h0, 4'hF, 1'b0);
      idle(5);
      wsamp(12'h000, 12'h000, 4'hA, 4'h0, 4'hF, 1'b0);
      idle(5);
      wsamp(12'h000, 12'h000, decay_on ? 4'h0 : 4'hA, decay_on ? 4'hF : 4'h0, 4'hF, 1'b0);
      for (int i = 0; i < 100; i++)
         wsamp(12'h000, 12'h000, decay_on ? 4'h0 : 4'hA, decay_on ? 4'hF : 4'h0, 4'hF, 1'b0);

      // Reset while floating, with a sample presented in the same cycle.
      wsamp(12'h00A, 12'h00F, 4'hA, 4'h0, 4'h0, 1'b0);
      wsamp(12'h000, 12'h000, 4'hA, 4'h0, 4'hF, 1'b0);
      @(negedge clk);
      rst = 1'b1; iv_w = 1'b1; drv_val = 12'h005; drv_en = 12'h00F;
      @(negedge clk);
      chk_reset("rst_sample");
      rst = 1'b0; iv_w = 1'b0;
      exp_cnt = 16'd0;

      // A conflict-unknown bit stays unknown while floating.
      wsamp(12'h01A, 12'h01F, 4'hA, 4'h1, 4'h0, 1'b1);
      wsamp(12'h000, 12'h000, 4'hA, 4'h1, 4'hF, 1'b0);
      wsamp(12'h000, 12'h000, 4'hA, 4'h1, 4'hF, 1'b0);
      idle(1);

      // Wired-OR / wired-AND instances.
      orand(12'h018, 12'hFFF, 4'h9, 4'h0);
      orand(12'hFFF, 12'hFFF, 4'hF, 4'hF);
      orand(12'h018, 12'h03C, 4'h9, 4'h9);
      idle(1);

      // Counter saturation.
      for (int i = 0; i < 65541; i++)
         wsamp(12'h01A, 12'h01F, 4'hA, 4'h1, 4'h0, 1'b1);
      idle(3);

      chk("wire_queue_drained", q_w.size(), 32'd0);
      chk("wor_queue_drained",  q_o.size(), 32'd0);
      chk("wand_queue_drained", q_a.size(), 32'd0);
      chk("final_cnt_saturated", {16'd0, w_c}, 32'h0000FFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
